// File: rtl/or16_stream_stage.sv
// Valid/ready stream stage: operand pairs queue in a small FIFO, the head is ORed
// and captured in an output register together with zero/negative flags.

module or16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  for (genvar gi = 0; gi < 16; gi++) begin : g_bit
    assign y[gi] = a[gi] | b[gi];
  end
endmodule

module or16_stream_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_zr,
  output logic        out_ng,
  output logic [15:0] txn_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [31:0]   head;
  logic [15:0]   or_result;
  logic          push;
  logic          pop;

  // in_ready comes only from the registered count, so out_ready never reaches it.
  assign in_ready = (count_reg < DEPTH_C);
  assign push     = in_valid && in_ready;
  assign pop      = (count_reg != '0) && (!out_valid || out_ready);
  assign head     = mem[rd_ptr_reg];

  or16 u_or16 (
    .a(head[31:16]),
    .b(head[15:0]),
    .y(or_result)
  );

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr_reg] <= {in_x, in_y};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_zr    <= 1'b1;
      out_ng    <= 1'b0;
      txn_count <= 16'h0000;
    end else begin
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= or_result;
        out_zr    <= (or_result == 16'h0000);
        out_ng    <= or_result[15];
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) begin
        txn_count <= txn_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_or16_stream_stage.sv
// Bench for or16_stream_stage: a queue model of pending results checked every
// cycle, plus directed scenarios with literal expectations.

module tb_or16_stream_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_x = 16'h0;
  logic [15:0] in_y = 16'h0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_zr;
  logic        out_ng;
  logic [15:0] txn_count;

  or16_stream_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_x(in_x),
    .in_y(in_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_zr(out_zr),
    .out_ng(out_ng),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: every accepted pair's result waits in order until it is handshaken out.
  // The result register is valid whenever something was left in the stage before
  // this edge's push; the rest of the queue is the FIFO.
  logic [15:0] q[$];
  bit          m_ov = 1'b0;
  logic [15:0] m_data = 16'h0000;
  logic [15:0] m_txn = 16'h0000;
  bit          m_push;
  bit          cmp_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ov   = 1'b0;
      m_data = 16'h0000;
      m_txn  = 16'h0000;
    end else begin
      m_push = in_valid && ((q.size() - int'(m_ov)) < DEPTH);
      if (m_ov && out_ready) begin
        void'(q.pop_front());
        m_txn = m_txn + 16'd1;
      end
      m_ov = (q.size() > 0);
      if (m_push) q.push_back(in_x | in_y);
      if (m_ov) m_data = q[0];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", out_valid, m_ov);
      chk("in_ready", in_ready, ((q.size() - int'(m_ov)) < DEPTH));
      chk("out_data", out_data, m_data);
      chk("out_zr", out_zr, (m_data == 16'h0000));
      chk("out_ng", out_ng, m_data[15]);
      chk("txn_count", txn_count, m_txn);
    end
  end

  logic [15:0] t3x [4];
  logic [15:0] t3y [4];

  initial begin
    int acc;
    int cyc;
    bit r;
    bit seen;
    t3x = '{16'h1000, 16'h0200, 16'h0030, 16'h0004};
    t3y = '{16'h0001, 16'h0020, 16'h0300, 16'h4000};

    // reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cmp_en = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_zr", out_zr, 1);
    chk("rst_ng", out_ng, 0);
    chk("rst_txn", txn_count, 0);
    chk("rst_ready", in_ready, 1);

    // 1: single pair, latency and first handshake
    in_x = 16'h00F0; in_y = 16'h0F00; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_valid_edge_k", out_valid, 0);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 16'h0FF0);
    chk("t1_zr", out_zr, 0);
    chk("t1_ng", out_ng, 0);
    step();
    chk("t1_txn", txn_count, 16'd1);
    chk("t1_drain", out_valid, 0);

    // 2: zero and negative results
    in_x = 16'h0000; in_y = 16'h0000; in_valid = 1'b1;
    step();
    in_x = 16'h8000; in_y = 16'h0001;
    step();
    in_valid = 1'b0;
    chk("t2_zero_data", out_data, 16'h0000);
    chk("t2_zero_zr", out_zr, 1);
    step();
    chk("t2_neg_data", out_data, 16'h8001);
    chk("t2_neg_ng", out_ng, 1);
    chk("t2_neg_zr", out_zr, 0);
    step();
    chk("t2_txn", txn_count, 16'd3);

    // 3: backpressure fills the stage, then release
    out_ready = 1'b0;
    acc = 0;
    for (int g = 0; g < 20 && acc < 3; g++) begin
      in_x = t3x[acc]; in_y = t3y[acc]; in_valid = 1'b1;
      r = in_ready;
      step();
      if (r) acc++;
    end
    in_x = t3x[3]; in_y = t3y[3];
    chk("t3_fill", acc, 3);
    chk("t3_full_ready", in_ready, 0);
    chk("t3_frozen", out_data, 16'h1001);
    step(); step(); step();
    chk("t3_still_frozen", out_data, 16'h1001);
    chk("t3_still_full", in_ready, 0);
    out_ready = 1'b1;
    for (int g = 0; g < 20 && acc < 4; g++) begin
      r = in_ready;
      step();
      if (r) acc++;
    end
    in_valid = 1'b0;
    chk("t3_all_in", acc, 4);
    for (int g = 0; g < 20 && out_valid; g++) step();
    chk("t3_drained", out_valid, 0);
    chk("t3_last", out_data, 16'h4004);
    chk("t3_txn", txn_count, 16'd7);

    // 4: 100 random pairs back to back
    acc = 0;
    cyc = 0;
    for (int g = 0; g < 300 && acc < 100; g++) begin
      in_x = 16'($urandom); in_y = 16'($urandom); in_valid = 1'b1;
      r = in_ready;
      step();
      cyc++;
      if (r) acc++;
    end
    in_valid = 1'b0;
    chk("t4_accepted", acc, 100);
    chk("t4_cycles", cyc, 100);
    for (int g = 0; g < 20 && out_valid; g++) step();
    chk("t4_txn", txn_count, 16'd107);

    // 5: reset with a full stage
    out_ready = 1'b0;
    for (int g = 0; g < 20 && in_ready; g++) begin
      in_x = 16'h1234; in_y = 16'h4321; in_valid = 1'b1;
      step();
    end
    chk("t5_full", in_ready, 0);
    chk("t5_valid", out_valid, 1);
    reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_txn", txn_count, 0);
    chk("t5_rst_zr", out_zr, 1);
    step(); step();
    chk("t5_no_stale", out_valid, 0);

    // 6: txn_count wraps after 65536 handshakes
    out_ready = 1'b1;
    acc = 0;
    seen = 1'b0;
    for (int g = 0; g < 70000 && acc < 65536; g++) begin
      in_x = 16'(g); in_y = 16'h0000; in_valid = 1'b1;
      r = in_ready;
      step();
      if (r) acc++;
      if (txn_count == 16'hFFFF) seen = 1'b1;
    end
    in_valid = 1'b0;
    for (int g = 0; g < 20 && out_valid; g++) begin
      step();
      if (txn_count == 16'hFFFF) seen = 1'b1;
    end
    chk("t6_accepted", acc, 65536);
    chk("t6_saw_ffff", seen, 1);
    chk("t6_wrap", txn_count, 16'h0000);
    chk("t6_drained", out_valid, 0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
